// File: rtl/ring_buffer_scheduler_if.sv
// Bundle of requester, completion, ring-buffer and commit signals of the ring buffer scheduler.
// The scheduler takes the slave view; its environment (requesters, ring buffer, committer) the master.
interface ring_buffer_scheduler_if #(
  parameter int unsigned NUM_ENTRIES    = 4,
  parameter int unsigned ENTRY_BITWIDTH = 16
);
  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic                      req0_call;
  logic                      req1_call;
  logic [ENTRY_BITWIDTH-1:0] req0_value;
  logic [ENTRY_BITWIDTH-1:0] req1_value;
  logic                      req0_rdy;
  logic                      req1_rdy;
  logic [IDX_W-1:0]          req0_index;
  logic [IDX_W-1:0]          req1_index;

  logic                      complete_call;
  logic [IDX_W-1:0]          complete_index;
  logic [ENTRY_BITWIDTH-1:0] complete_value;

  logic                      rb_alloc_call;
  logic [ENTRY_BITWIDTH-1:0] rb_alloc_value;
  logic                      rb_alloc_rdy;
  logic [IDX_W-1:0]          rb_alloc_index;
  logic                      rb_update_call;
  logic [IDX_W-1:0]          rb_update_index;
  logic [ENTRY_BITWIDTH-1:0] rb_update_value;
  logic                      rb_remove_call;
  logic                      rb_remove_rdy;
  logic                      rb_peek_call;
  logic                      rb_peek_rdy;
  logic [ENTRY_BITWIDTH-1:0] rb_peek_value;

  logic                      commit_valid;
  logic [ENTRY_BITWIDTH-1:0] commit_value;
  logic                      commit_rdy;
  logic [7:0]                commit_count;

  modport slave (
    input  req0_call, req1_call, req0_value, req1_value,
    input  complete_call, complete_index, complete_value,
    input  rb_alloc_rdy, rb_alloc_index, rb_remove_rdy, rb_peek_rdy, rb_peek_value,
    input  commit_rdy,
    output req0_rdy, req1_rdy, req0_index, req1_index,
    output rb_alloc_call, rb_alloc_value, rb_update_call, rb_update_index, rb_update_value,
    output rb_remove_call, rb_peek_call,
    output commit_valid, commit_value, commit_count
  );

  modport master (
    output req0_call, req1_call, req0_value, req1_value,
    output complete_call, complete_index, complete_value,
    output rb_alloc_rdy, rb_alloc_index, rb_remove_rdy, rb_peek_rdy, rb_peek_value,
    output commit_rdy,
    input  req0_rdy, req1_rdy, req0_index, req1_index,
    input  rb_alloc_call, rb_alloc_value, rb_update_call, rb_update_index, rb_update_value,
    input  rb_remove_call, rb_peek_call,
    input  commit_valid, commit_value, commit_count
  );
endinterface

// File: rtl/ring_buffer_scheduler.sv
// Round-robin allocator for two requesters into a ring buffer, with out-of-order completion
// tracking and in-order commit from the ring buffer head.
module ring_buffer_scheduler #(
  parameter int unsigned NUM_ENTRIES    = 4,
  parameter int unsigned ENTRY_BITWIDTH = 16
) (
  input logic                          clk,
  input logic                          reset,
  ring_buffer_scheduler_if.slave       bus
);
  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic                   prio_q, prio_d;
  logic [IDX_W-1:0]       head_q, head_d;
  logic [NUM_ENTRIES-1:0] done_q, done_d;
  logic [7:0]             count_q, count_d;

  logic                      req0_rdy, req1_rdy, grant0, grant1;
  logic                      head_done, commit_valid, fire;
  logic [ENTRY_BITWIDTH-1:0] alloc_value, commit_value;

  // The ring buffer only removes when it is non-empty, so its remove_rdy adds no information.
  logic unused_remove_rdy;
  assign unused_remove_rdy = bus.rb_remove_rdy;

  always_comb begin
    req0_rdy     = bus.rb_alloc_rdy & (~prio_q | ~bus.req1_call);
    req1_rdy     = bus.rb_alloc_rdy & (prio_q | ~bus.req0_call);
    grant0       = bus.req0_call & req0_rdy;
    grant1       = bus.req1_call & req1_rdy;
    alloc_value  = '0;
    if (grant0) begin
      alloc_value = bus.req0_value;
    end else if (grant1) begin
      alloc_value = bus.req1_value;
    end
    head_done    = done_q[head_q];
    commit_valid = bus.rb_peek_rdy & head_done;
    commit_value = commit_valid ? bus.rb_peek_value : '0;
    fire         = commit_valid & bus.commit_rdy;
  end

  always_comb begin
    prio_d  = prio_q;
    head_d  = head_q;
    done_d  = done_q;
    count_d = count_q;
    if (grant0) begin
      prio_d = 1'b1;
    end else if (grant1) begin
      prio_d = 1'b0;
    end
    if (bus.complete_call) begin
      done_d[bus.complete_index] = 1'b1;
    end
    // Retire and allocation clears are applied last so they override a same-slot completion.
    if (fire) begin
      done_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
      count_d        = count_q + 8'd1;
    end
    if (grant0 | grant1) begin
      done_d[bus.rb_alloc_index] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q  <= 1'b0;
      head_q  <= '0;
      done_q  <= '0;
      count_q <= 8'd0;
    end else begin
      prio_q  <= prio_d;
      head_q  <= head_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign bus.req0_rdy        = req0_rdy;
  assign bus.req1_rdy        = req1_rdy;
  assign bus.req0_index      = bus.rb_alloc_index;
  assign bus.req1_index      = bus.rb_alloc_index;
  assign bus.rb_alloc_call   = grant0 | grant1;
  assign bus.rb_alloc_value  = alloc_value;
  assign bus.rb_update_call  = bus.complete_call;
  assign bus.rb_update_index = bus.complete_index;
  assign bus.rb_update_value = bus.complete_value;
  assign bus.rb_peek_call    = head_done;
  assign bus.rb_remove_call  = fire;
  assign bus.commit_valid    = commit_valid;
  assign bus.commit_value    = commit_value;
  assign bus.commit_count    = count_q;

endmodule

// File: tb/tb_ring_buffer_scheduler.sv
// Randomized and directed bench for ring_buffer_scheduler: a ring buffer environment model plus
// a queue-based reference of allocation order, completions and commits.
module tb_ring_buffer_scheduler;
  localparam int unsigned NUM = 4;
  localparam int unsigned W   = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ring_buffer_scheduler_if #(.NUM_ENTRIES(NUM), .ENTRY_BITWIDTH(W)) bus ();

  ring_buffer_scheduler #(.NUM_ENTRIES(NUM), .ENTRY_BITWIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Ring buffer environment: count is registered, so a full buffer stays full for the fire cycle.
  int unsigned   env_cnt;
  logic [1:0]    env_tail, env_head;
  logic [W-1:0]  env_data [NUM];

  assign bus.rb_alloc_rdy   = (env_cnt < NUM);
  assign bus.rb_alloc_index = env_tail;
  assign bus.rb_remove_rdy  = 1'b1;
  assign bus.rb_peek_rdy    = (env_cnt > 0);
  assign bus.rb_peek_value  = env_data[env_head];

  // Reference: slots in allocation order, per-slot completion flag and completion value.
  logic [1:0]   q_slots [$];
  bit           m_done [NUM];
  logic [W-1:0] m_val  [NUM];
  bit           m_prio;
  logic [7:0]   m_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic         obs_rdy0, obs_rdy1, obs_acall, obs_cvalid, obs_remove;
  logic [1:0]   obs_idx0;
  logic [W-1:0] obs_avalue, obs_cvalue;
  logic [7:0]   obs_count;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_state();
    env_cnt  = 0;
    env_tail = 2'd0;
    env_head = 2'd0;
    for (int i = 0; i < NUM; i++) begin
      env_data[i] = '0;
      m_done[i]   = 1'b0;
      m_val[i]    = '0;
    end
    q_slots.delete();
    m_prio  = 1'b0;
    m_count = 8'd0;
  endtask

  task automatic step(input bit c0, input bit c1, input logic [W-1:0] v0, input logic [W-1:0] v1,
                      input bit cc, input logic [1:0] ci, input logic [W-1:0] cv,
                      input bit crdy);
    bit           ar, e_rdy0, e_rdy1, g0, g1, e_valid, fire;
    logic [W-1:0] e_aval, e_cval;
    logic [1:0]   slot;
    @(negedge clk);
    bus.req0_call      = c0;
    bus.req1_call      = c1;
    bus.req0_value     = v0;
    bus.req1_value     = v1;
    bus.complete_call  = cc;
    bus.complete_index = ci;
    bus.complete_value = cv;
    bus.commit_rdy     = crdy;
    #1;
    ar      = (env_cnt < NUM);
    e_rdy0  = ar && (!m_prio || !c1);
    e_rdy1  = ar && (m_prio || !c0);
    g0      = c0 && e_rdy0;
    g1      = c1 && e_rdy1;
    e_aval  = g0 ? v0 : (g1 ? v1 : '0);
    e_valid = (q_slots.size() > 0) && m_done[q_slots[0]];
    e_cval  = e_valid ? m_val[q_slots[0]] : '0;
    fire    = e_valid && crdy;

    obs_rdy0   = bus.req0_rdy;
    obs_rdy1   = bus.req1_rdy;
    obs_acall  = bus.rb_alloc_call;
    obs_avalue = bus.rb_alloc_value;
    obs_idx0   = bus.req0_index;
    obs_cvalid = bus.commit_valid;
    obs_cvalue = bus.commit_value;
    obs_remove = bus.rb_remove_call;
    obs_count  = bus.commit_count;

    check_eq("req0_rdy", obs_rdy0, e_rdy0);
    check_eq("req1_rdy", obs_rdy1, e_rdy1);
    check_eq("alloc_call", obs_acall, g0 | g1);
    check_eq("alloc_value", obs_avalue, e_aval);
    if (g0 | g1) begin
      check_eq("req0_index", obs_idx0, env_tail);
      check_eq("req1_index", bus.req1_index, env_tail);
    end
    check_eq("update_call", bus.rb_update_call, cc);
    if (cc) begin
      check_eq("update_index", bus.rb_update_index, ci);
      check_eq("update_value", bus.rb_update_value, cv);
    end
    check_eq("peek_call", bus.rb_peek_call, e_valid);
    check_eq("commit_valid", obs_cvalid, e_valid);
    check_eq("commit_value", obs_cvalue, e_cval);
    check_eq("remove_call", obs_remove, fire);
    check_eq("commit_count", obs_count, m_count);

    @(posedge clk);
    #1;
    slot = env_tail;
    if (g0 | g1) begin
      env_data[env_tail] = e_aval;
      env_tail++;
      env_cnt++;
    end
    if (cc) env_data[ci] = cv;
    if (fire) begin
      env_head++;
      env_cnt--;
    end
    if (cc) begin
      m_done[ci] = 1'b1;
      m_val[ci]  = cv;
    end
    if (fire) begin
      m_done[q_slots[0]] = 1'b0;
      void'(q_slots.pop_front());
      m_count++;
    end
    if (g0 | g1) begin
      q_slots.push_back(slot);
      m_done[slot] = 1'b0;
    end
    if (g0) m_prio = 1'b1;
    else if (g1) m_prio = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset              = 1'b1;
    bus.req0_call      = 1'b0;
    bus.req1_call      = 1'b0;
    bus.complete_call  = 1'b0;
    bus.commit_rdy     = 1'b0;
    @(posedge clk);
    #1;
    clear_state();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_commit_valid", bus.commit_valid, 1'b0);
    check_eq("rst_commit_count", bus.commit_count, 8'd0);
    check_eq("rst_peek_call", bus.rb_peek_call, 1'b0);
    check_eq("rst_req0_rdy", bus.req0_rdy, 1'b1);
  endtask

  task automatic random_steps(input int n);
    logic [1:0] pend [$];
    bit         cc;
    logic [1:0] ci;
    for (int k = 0; k < n; k++) begin
      pend.delete();
      foreach (q_slots[j]) if (!m_done[q_slots[j]]) pend.push_back(q_slots[j]);
      cc = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
      ci = cc ? pend[$urandom_range(0, pend.size() - 1)] : 2'(k);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, W'($urandom), W'($urandom),
           cc, ci, W'($urandom), $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.req0_call      = 1'b0;
    bus.req1_call      = 1'b0;
    bus.req0_value     = '0;
    bus.req1_value     = '0;
    bus.complete_call  = 1'b0;
    bus.complete_index = '0;
    bus.complete_value = '0;
    bus.commit_rdy     = 1'b0;
    clear_state();
    repeat (2) @(posedge clk);
    do_reset();

    // Round-robin between two contenders on an empty buffer.
    step(1, 1, 16'hA000, 16'hA001, 0, 2'd0, 16'h0, 0);
    check_eq("rr0_rdy0", obs_rdy0, 1'b1);
    check_eq("rr0_idx", obs_idx0, 2'd0);
    step(1, 1, 16'hA002, 16'hA001, 0, 2'd0, 16'h0, 0);
    check_eq("rr1_rdy1", obs_rdy1, 1'b1);
    check_eq("rr1_value", obs_avalue, 16'hA001);
    check_eq("rr1_idx", obs_idx0, 2'd1);
    step(1, 1, 16'hA002, 16'hA003, 0, 2'd0, 16'h0, 0);
    check_eq("rr2_rdy0", obs_rdy0, 1'b1);
    check_eq("rr2_idx", obs_idx0, 2'd2);
    step(0, 1, 16'h0, 16'hA003, 0, 2'd0, 16'h0, 0);
    check_eq("fill_idx", obs_idx0, 2'd3);

    // Full buffer: no grant; out-of-order completion of slot 2 must not commit.
    step(1, 0, 16'hBEEF, 16'h0, 1, 2'd2, 16'h5502, 1);
    check_eq("full_rdy0", obs_rdy0, 1'b0);
    check_eq("full_alloc", obs_acall, 1'b0);
    step(1, 1, 16'hBEEF, 16'hBEEF, 1, 2'd0, 16'h5500, 1);
    check_eq("ooo_valid", obs_cvalid, 1'b0);
    step(0, 0, 16'h0, 16'h0, 0, 2'd0, 16'h0, 0);
    check_eq("head_valid", obs_cvalid, 1'b1);
    check_eq("head_value", obs_cvalue, 16'h5500);
    check_eq("hold_remove", obs_remove, 1'b0);
    step(0, 0, 16'h0, 16'h0, 0, 2'd0, 16'h0, 0);
    check_eq("hold_value", obs_cvalue, 16'h5500);
    step(0, 0, 16'h0, 16'h0, 0, 2'd0, 16'h0, 1);
    check_eq("fire_remove", obs_remove, 1'b1);
    step(1, 1, 16'hB000, 16'hB001, 0, 2'd0, 16'h0, 1);
    check_eq("post_count", obs_count, 8'd1);
    check_eq("post_valid", obs_cvalid, 1'b0);
    check_eq("prio_kept", obs_rdy0, 1'b1);
    check_eq("wrap_idx", obs_idx0, 2'd0);

    // Long random run covers head wrap, commit_count wrap and in-order commit values.
    random_steps(800);

    // Reset in the middle of traffic, then the first grant must start from a clean state.
    step(0, 0, 16'h0, 16'h0, 0, 2'd0, 16'h0, 0);
    if (q_slots.size() > 0 && !m_done[q_slots[0]])
      step(0, 0, 16'h0, 16'h0, 1, q_slots[0], 16'h7777, 0);
    do_reset();
    step(1, 1, 16'hC000, 16'hC001, 0, 2'd0, 16'h0, 1);
    check_eq("mid_rst_valid", obs_cvalid, 1'b0);
    check_eq("mid_rst_count", obs_count, 8'd0);
    check_eq("mid_rst_prio", obs_rdy0, 1'b1);
    check_eq("mid_rst_idx", obs_idx0, 2'd0);
    random_steps(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ring_buffer_scheduler.md
RING_BUFFER_SCHEDULER -- requirements
Module: ring_buffer_scheduler

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4: ring buffer depth; must be a power of two.
REQ-002 SHALL have parameter ENTRY_BITWIDTH, default 16: entry payload width.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports req0_call / req1_call, input, 1 each: allocation requests from requesters 0 and 1.
REQ-006 SHALL have ports req0_value / req1_value, input, ENTRY_BITWIDTH each: payloads to allocate.
REQ-007 SHALL have ports req0_rdy / req1_rdy, output, 1 each: the requester may call this cycle.
REQ-008 SHALL have ports req0_index / req1_index, output, log2(NUM_ENTRIES) each: slot granted to the requester.
REQ-009 SHALL have ports complete_call, input, 1; complete_index, input, log2(NUM_ENTRIES); complete_value, input, ENTRY_BITWIDTH: marks a slot done and writes its result.
REQ-010 SHALL have ports rb_alloc_call, output, 1; rb_alloc_value, output, ENTRY_BITWIDTH; rb_alloc_rdy, input, 1; rb_alloc_index, input, log2(NUM_ENTRIES): ring buffer alloc port.
REQ-011 SHALL have ports rb_update_call, output, 1; rb_update_index, output, log2(NUM_ENTRIES); rb_update_value, output, ENTRY_BITWIDTH: ring buffer update port.
REQ-012 SHALL have ports rb_remove_call, output, 1; rb_remove_rdy, input, 1; rb_peek_call, output, 1; rb_peek_rdy, input, 1; rb_peek_value, input, ENTRY_BITWIDTH: ring buffer remove and peek ports.
REQ-013 SHALL have ports commit_valid, output, 1; commit_value, output, ENTRY_BITWIDTH; commit_rdy, input, 1: in-order commit stream.
REQ-014 SHALL have port commit_count, output, 8: number of commits, wrapping modulo 256.

Function
REQ-015 SHALL hold state: prio (1 bit), head (log2(NUM_ENTRIES) bits), done[NUM_ENTRIES], commit_count.
REQ-016 SHALL drive req0_rdy = rb_alloc_rdy & (prio==0 | !req1_call), and req1_rdy = rb_alloc_rdy & (prio==1 | !req0_call).
REQ-017 SHALL define grantN = reqN_call & reqN_rdy; a call while not rdy is a protocol violation with undefined effect.
REQ-018 SHALL drive rb_alloc_call = grant0|grant1 and rb_alloc_value = the granted requester's value (0 when no grant).
REQ-019 SHALL drive req0_index = req1_index = rb_alloc_index combinationally; both outputs are meaningful only in a grant cycle.
REQ-020 SHALL update prio to 1 after grant0, to 0 after grant1, and leave it unchanged with no grant (round-robin between contenders).
REQ-021 SHALL pass complete_call/index/value straight to rb_update_call/index/value in the same cycle.
REQ-022 SHALL set done[complete_index] at the clock edge when complete_call is high.
REQ-023 SHALL clear done[rb_alloc_index] on a grant; when alloc and complete target the same index in one cycle, clear wins.
REQ-024 SHALL drive rb_peek_call = done[head] and commit_valid = rb_peek_rdy & done[head].
REQ-025 SHALL drive commit_value = rb_peek_value when commit_valid is high, and 0 otherwise.
REQ-026 SHALL define commit fire = commit_valid & commit_rdy, and SHALL drive rb_remove_call = fire.
REQ-027 SHALL, on fire: clear done[head]; advance head by 1 modulo NUM_ENTRIES (wrap 3 -> 0); increment commit_count modulo 256.
REQ-028 SHALL, when complete sets done[head] in the same cycle as fire on that slot, leave the bit cleared.
REQ-029 SHALL make a completion visible on commit_valid no earlier than the cycle after complete_call (zero-bypass, one-cycle latency).
REQ-030 SHALL support alloc, update and commit in the same cycle, including on a full buffer, where fire frees space only from the next cycle because rb_alloc_rdy comes from registered count.

Reset
REQ-031 SHALL, on reset high at a rising edge: prio=0, head=0, all done=0, commit_count=0, regardless of in-flight requests.
REQ-032 SHALL, while reset is asserted, still compute all outputs combinationally from state; the ring buffer itself is reset by the same reset signal.

Verification
REQ-033 SHALL cover: after reset, req0_call=1 and req1_call=1 with buffer empty -> cycle 0 grants req0 (index 0), cycle 1 grants req1 (index 1), cycle 2 grants req0 again.
REQ-034 SHALL cover: alloc slots 0..3 with 0xA000..0xA003, then complete slot 2 only -> commit_valid stays 0; complete slot 0 -> next cycle commit_valid=1 with commit_value equal to slot 0's written completion value.
REQ-035 SHALL cover: buffer full (rb_alloc_rdy=0) with req0_call=1 -> req0_rdy=0, rb_alloc_call=0, and prio unchanged.
REQ-036 SHALL cover: commit_rdy=0 with done[head]=1 -> commit_valid=1, rb_remove_call=0, head held; raise commit_rdy -> one remove, head+1, commit_count+1.
REQ-037 SHALL cover: 6 alloc/complete/commit rounds -> head wraps 3 -> 0, commit_count=6, commits in allocation order.
REQ-038 SHALL cover: reset asserted mid-stream with done bits set -> next cycle commit_valid=0, commit_count=0, head=0, prio=0.
